// File: rtl/fetch_stage_if.sv
// Signal bundle between the fetch stage, instruction memory and the decode stage.
// The master modport is the fetch side. The slave modport is the memory/decode side.
interface fetch_stage_if;
  logic        stallD;
  logic        redirect;
  logic [15:0] redirectPC;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata;
  logic        imem_done;
  logic        imem_err;
  logic [15:0] instructionF;
  logic [15:0] incPCF;
  logic        validF;
  logic        errF;
  logic        haltF;

  modport master (
    input  stallD, redirect, redirectPC, imem_rdata, imem_done, imem_err,
    output imem_req, imem_addr, instructionF, incPCF, validF, errF, haltF
  );

  modport slave (
    output stallD, redirect, redirectPC, imem_rdata, imem_done, imem_err,
    input  imem_req, imem_addr, instructionF, incPCF, validF, errF, haltF
  );
endinterface

// File: rtl/fetch_stage.sv
// WISC instruction-fetch stage: owns the PC, keeps one memory request outstanding at a time,
// and holds the fetched word in a one-entry buffer until decode accepts it.
module fetch_stage #(
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter logic [4:0]  HALT_OPCODE = 5'b00000
) (
  input  logic          clk,
  input  logic          rst,
  fetch_stage_if.master bus
);

  typedef enum logic [1:0] {FETCH, WAIT, FULL, HALT} state_t;

  state_t      state, state_nxt;
  logic [15:0] pc;
  logic [15:0] instr_q;
  logic [15:0] incpc_q;
  logic        valid;
  logic        drop;
  logic        err_q;
  logic        is_halt;

  assign is_halt = (bus.imem_rdata[15:11] == HALT_OPCODE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= FETCH;
    else      state <= state_nxt;
  end

  // A redirect always wins: a response that arrives with it, or after it, is discarded.
  always_comb begin
    state_nxt = state;
    unique case (state)
      FETCH: if (!bus.redirect) state_nxt = WAIT;
      WAIT: begin
        if (bus.imem_done) begin
          if (bus.redirect || drop)               state_nxt = FETCH;
          else if (bus.imem_err || is_halt)       state_nxt = HALT;
          else                                    state_nxt = FULL;
        end
      end
      FULL: if (bus.redirect || !bus.stallD)      state_nxt = FETCH;
      HALT: if (valid && bus.redirect)            state_nxt = FETCH;
      default:                                    state_nxt = FETCH;
    endcase
  end

  // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc      <= RESET_PC;
      instr_q <= 16'h0000;
      incpc_q <= 16'h0000;
      valid   <= 1'b0;
      drop    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      unique case (state)
        FETCH: if (bus.redirect) pc <= bus.redirectPC;
        WAIT: begin
          if (bus.redirect) begin
            pc   <= bus.redirectPC;
            drop <= !bus.imem_done;
          end else if (bus.imem_done) begin
            if (drop) begin
              drop <= 1'b0;
            end else begin
              instr_q <= bus.imem_rdata;
              incpc_q <= pc + 16'd2;
              pc      <= pc + 16'd2;
              valid   <= 1'b1;
              err_q   <= bus.imem_err;
            end
          end
        end
        FULL: begin
          if (bus.redirect) begin
            valid <= 1'b0;
            pc    <= bus.redirectPC;
          end else if (!bus.stallD) begin
            valid <= 1'b0;
          end
        end
        HALT: begin
          // Once the buffer has drained, redirects no longer matter; only reset leaves HALT.
          if (valid) begin
            if (bus.redirect) begin
              valid <= 1'b0;
              err_q <= 1'b0;
              pc    <= bus.redirectPC;
            end else if (!bus.stallD) begin
              valid <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: every output gets a default first so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    bus.imem_req     = 1'b0;
    bus.imem_addr    = pc;
    bus.haltF        = 1'b0;
    bus.validF       = valid & ~bus.redirect;
    bus.instructionF = instr_q;
    bus.incPCF       = incpc_q;
    bus.errF         = err_q;
    unique case (state)
      FETCH:   bus.imem_req = 1'b1;
      HALT:    bus.haltF    = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus a randomized run against
// a transaction-level model of the sequential instruction stream.
module tb_fetch_stage;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fetch_stage_if ifc ();

  fetch_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Memory model: sparse overrides on top of a non-halt default pattern.
  logic [15:0] mem_ovr [logic [15:0]];
  bit          mem_en   = 1'b1;
  bit          err_en   = 1'b0;
  logic [15:0] err_addr = 16'h0000;
  int          lat_lo   = 1;
  int          lat_hi   = 1;

  function automatic logic [15:0] mem_val(input logic [15:0] a);
    if (mem_ovr.exists(a)) return mem_ovr[a];
    return {2'b01, a[13:0] ^ 14'h2a5c};
  endfunction

  initial begin
    ifc.stallD     = 1'b0;
    ifc.redirect   = 1'b0;
    ifc.redirectPC = 16'h0000;
    ifc.imem_rdata = 16'h0000;
    ifc.imem_done  = 1'b0;
    ifc.imem_err   = 1'b0;
  end

  // Responder: acts 1 time unit after each falling edge; answers each request after lat cycles.
  initial begin : responder
    int          cnt;
    logic [15:0] a;
    bit          busy;
    busy = 1'b0;
    cnt  = 0;
    a    = 16'h0000;
    forever begin
      @(negedge clk);
      #1;
      if (!mem_en) begin
        busy = 1'b0;
      end else if (!rst) begin
        busy          = 1'b0;
        ifc.imem_done = 1'b0;
        ifc.imem_err  = 1'b0;
      end else begin
        ifc.imem_done = 1'b0;
        ifc.imem_err  = 1'b0;
        if (busy) begin
          cnt--;
          if (cnt == 0) begin
            ifc.imem_done  = 1'b1;
            ifc.imem_rdata = mem_val(a);
            ifc.imem_err   = err_en && (a == err_addr);
            busy           = 1'b0;
          end
        end else if (ifc.imem_req) begin
          busy = 1'b1;
          a    = ifc.imem_addr;
          cnt  = $urandom_range(lat_hi, lat_lo);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Inputs are driven on the falling edge; outputs are sampled 2 units later.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic look();
    #2;
  endtask

  task automatic do_reset();
    tick();
    rst            = 1'b0;
    ifc.stallD     = 1'b0;
    ifc.redirect   = 1'b0;
    ifc.redirectPC = 16'h0000;
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    tick();
    rst = 1'b0;
    look();
    n_cmp++; if (ifc.validF !== 1'b0)           begin n_bad++; $display("FAIL reset_validF got %b want 0", ifc.validF); end
    n_cmp++; if (ifc.instructionF !== 16'h0000) begin n_bad++; $display("FAIL reset_instr got %h want 0000", ifc.instructionF); end
    n_cmp++; if (ifc.incPCF !== 16'h0000)       begin n_bad++; $display("FAIL reset_incPCF got %h want 0000", ifc.incPCF); end
    n_cmp++; if (ifc.errF !== 1'b0)             begin n_bad++; $display("FAIL reset_errF got %b want 0", ifc.errF); end
    n_cmp++; if (ifc.haltF !== 1'b0)            begin n_bad++; $display("FAIL reset_haltF got %b want 0", ifc.haltF); end
    n_cmp++; if (ifc.imem_addr !== 16'h0000)    begin n_bad++; $display("FAIL reset_addr got %h want 0000", ifc.imem_addr); end
  endtask

  task automatic test_sequential();
    logic [15:0] addrs[$];
    logic [15:0] instrs[$];
    logic [15:0] incs[$];
    int          vcyc[$];
    mem_ovr.delete();
    mem_ovr[16'h0000] = 16'h4001;
    mem_ovr[16'h0002] = 16'h4002;
    lat_lo = 1; lat_hi = 1;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      look();
      if (ifc.imem_req) addrs.push_back(ifc.imem_addr);
      if (ifc.validF) begin
        instrs.push_back(ifc.instructionF);
        incs.push_back(ifc.incPCF);
        vcyc.push_back(i);
      end
      if (addrs.size() >= 3 && instrs.size() >= 2) break;
      tick();
    end
    n_cmp++;
    if (addrs.size() < 3 || instrs.size() < 2) begin
      n_bad++;
      $display("FAIL seq_progress got %0d reqs %0d valids want 3 and 2", addrs.size(), instrs.size());
    end else begin
      n_cmp++; if (addrs[0] !== 16'h0000)  begin n_bad++; $display("FAIL seq_addr0 got %h want 0000", addrs[0]); end
      n_cmp++; if (addrs[1] !== 16'h0002)  begin n_bad++; $display("FAIL seq_addr1 got %h want 0002", addrs[1]); end
      n_cmp++; if (addrs[2] !== 16'h0004)  begin n_bad++; $display("FAIL seq_addr2 got %h want 0004", addrs[2]); end
      n_cmp++; if (instrs[0] !== 16'h4001) begin n_bad++; $display("FAIL seq_instr0 got %h want 4001", instrs[0]); end
      n_cmp++; if (incs[0] !== 16'h0002)   begin n_bad++; $display("FAIL seq_inc0 got %h want 0002", incs[0]); end
      n_cmp++; if (instrs[1] !== 16'h4002) begin n_bad++; $display("FAIL seq_instr1 got %h want 4002", instrs[1]); end
      n_cmp++; if (incs[1] !== 16'h0004)   begin n_bad++; $display("FAIL seq_inc1 got %h want 0004", incs[1]); end
      n_cmp++; if (vcyc[1] - vcyc[0] != 3) begin n_bad++; $display("FAIL seq_rate got %0d cycles want 3", vcyc[1] - vcyc[0]); end
    end
    tick();
  endtask

  task automatic test_stall();
    logic [15:0] held_i;
    logic [15:0] held_p;
    bit          found;
    mem_ovr.delete();
    lat_lo = 1; lat_hi = 1;
    do_reset();
    ifc.stallD = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      look();
      if (ifc.validF) found = 1'b1;
      else tick();
    end
    n_cmp++; if (!found) begin n_bad++; $display("FAIL stall_timeout got no validF want validF within 20 cycles"); end
    held_i = ifc.instructionF;
    held_p = ifc.incPCF;
    n_cmp++; if (held_i !== mem_val(16'h0000)) begin n_bad++; $display("FAIL stall_instr got %h want %h", held_i, mem_val(16'h0000)); end
    for (int i = 0; i < 4; i++) begin
      tick();
      look();
      n_cmp++;
      if (ifc.instructionF !== held_i || ifc.incPCF !== held_p || ifc.imem_req !== 1'b0 || ifc.validF !== 1'b1) begin
        n_bad++;
        $display("FAIL stall_hold got instr %h inc %h req %b valid %b want %h %h 0 1",
                 ifc.instructionF, ifc.incPCF, ifc.imem_req, ifc.validF, held_i, held_p);
      end
    end
    tick();
    ifc.stallD = 1'b0;
    look();
    tick();
    look();
    n_cmp++;
    if (ifc.imem_req !== 1'b1 || ifc.imem_addr !== held_p) begin
      n_bad++;
      $display("FAIL stall_next_req got req %b addr %h want 1 %h", ifc.imem_req, ifc.imem_addr, held_p);
    end
    tick();
  endtask

  task automatic test_redirect_wait();
    bit          found;
    bit          early_valid;
    logic [15:0] first_addr;
    mem_ovr.delete();
    lat_lo = 3; lat_hi = 3;
    do_reset();
    look();
    n_cmp++; if (ifc.imem_req !== 1'b1) begin n_bad++; $display("FAIL rdw_first_req got %b want 1", ifc.imem_req); end
    tick();
    ifc.redirect   = 1'b1;
    ifc.redirectPC = 16'h0100;
    look();
    tick();
    ifc.redirect = 1'b0;
    found       = 1'b0;
    early_valid = 1'b0;
    first_addr  = 16'hxxxx;
    for (int i = 0; i < 10 && !found; i++) begin
      look();
      if (ifc.validF) early_valid = 1'b1;
      if (ifc.imem_req) begin found = 1'b1; first_addr = ifc.imem_addr; end
      else tick();
    end
    n_cmp++; if (early_valid)               begin n_bad++; $display("FAIL rdw_discard got validF 1 want 0"); end
    n_cmp++; if (!found)                    begin n_bad++; $display("FAIL rdw_timeout got no request want request"); end
    n_cmp++; if (first_addr !== 16'h0100)   begin n_bad++; $display("FAIL rdw_addr got %h want 0100", first_addr); end
    lat_lo = 1; lat_hi = 1;
    tick();
  endtask

  task automatic test_halt();
    bit found;
    mem_ovr.delete();
    mem_ovr[16'h0006] = 16'h0000;
    lat_lo = 1; lat_hi = 2;
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      look();
      if (ifc.haltF) found = 1'b1;
      else tick();
    end
    n_cmp++; if (!found) begin n_bad++; $display("FAIL halt_timeout got no haltF want haltF"); end
    n_cmp++;
    if (ifc.validF !== 1'b1 || ifc.instructionF !== 16'h0000 || ifc.incPCF !== 16'h0008 || ifc.errF !== 1'b0) begin
      n_bad++;
      $display("FAIL halt_word got valid %b instr %h inc %h err %b want 1 0000 0008 0",
               ifc.validF, ifc.instructionF, ifc.incPCF, ifc.errF);
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      ifc.redirect   = (i == 5);
      ifc.redirectPC = 16'h0200;
      look();
      n_cmp++;
      if (ifc.imem_req !== 1'b0 || ifc.validF !== 1'b0 || ifc.haltF !== 1'b1) begin
        n_bad++;
        $display("FAIL halt_idle got req %b valid %b halt %b want 0 0 1", ifc.imem_req, ifc.validF, ifc.haltF);
      end
    end
    ifc.redirect = 1'b0;
    tick();
  endtask

  task automatic test_error();
    bit found;
    mem_ovr.delete();
    lat_lo = 1; lat_hi = 1;
    err_en   = 1'b1;
    err_addr = 16'h0000;
    do_reset();
    ifc.stallD = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      look();
      if (ifc.haltF) found = 1'b1;
      else tick();
    end
    n_cmp++; if (!found) begin n_bad++; $display("FAIL err_timeout got no haltF want haltF"); end
    n_cmp++;
    if (ifc.errF !== 1'b1 || ifc.validF !== 1'b1 || ifc.incPCF !== 16'h0002) begin
      n_bad++;
      $display("FAIL err_flag got err %b valid %b inc %h want 1 1 0002", ifc.errF, ifc.validF, ifc.incPCF);
    end
    tick();
    ifc.redirect   = 1'b1;
    ifc.redirectPC = 16'h0020;
    look();
    n_cmp++; if (ifc.validF !== 1'b0) begin n_bad++; $display("FAIL err_mask got validF %b want 0", ifc.validF); end
    tick();
    ifc.redirect = 1'b0;
    err_en       = 1'b0;
    look();
    n_cmp++;
    if (ifc.errF !== 1'b0 || ifc.haltF !== 1'b0 || ifc.imem_req !== 1'b1 || ifc.imem_addr !== 16'h0020) begin
      n_bad++;
      $display("FAIL err_flush got err %b halt %b req %b addr %h want 0 0 1 0020",
               ifc.errF, ifc.haltF, ifc.imem_req, ifc.imem_addr);
    end
    ifc.stallD = 1'b0;
    tick();
  endtask

  task automatic test_reset_wait();
    mem_en = 1'b0;
    ifc.imem_done = 1'b0;
    ifc.imem_err  = 1'b0;
    do_reset();
    ifc.stallD = 1'b1;
    look();
    n_cmp++; if (ifc.imem_req !== 1'b1) begin n_bad++; $display("FAIL rw_req got %b want 1", ifc.imem_req); end
    tick();
    rst = 1'b0;
    look();
    tick();
    rst            = 1'b1;
    ifc.imem_done  = 1'b1;
    ifc.imem_rdata = 16'hffff;
    look();
    n_cmp++;
    if (ifc.imem_req !== 1'b1 || ifc.imem_addr !== 16'h0000) begin
      n_bad++;
      $display("FAIL rw_restart got req %b addr %h want 1 0000", ifc.imem_req, ifc.imem_addr);
    end
    tick();
    ifc.imem_done = 1'b0;
    look();
    n_cmp++; if (ifc.validF !== 1'b0 || ifc.imem_req !== 1'b0) begin n_bad++; $display("FAIL rw_stale got valid %b req %b want 0 0", ifc.validF, ifc.imem_req); end
    tick();
    ifc.imem_done  = 1'b1;
    ifc.imem_rdata = 16'h4321;
    look();
    tick();
    ifc.imem_done = 1'b0;
    look();
    n_cmp++;
    if (ifc.validF !== 1'b1 || ifc.instructionF !== 16'h4321 || ifc.incPCF !== 16'h0002) begin
      n_bad++;
      $display("FAIL rw_real got valid %b instr %h inc %h want 1 4321 0002", ifc.validF, ifc.instructionF, ifc.incPCF);
    end
    tick();
    ifc.redirect   = 1'b1;
    ifc.redirectPC = 16'hfffe;
    look();
    tick();
    ifc.redirect = 1'b0;
    look();
    n_cmp++; if (ifc.imem_addr !== 16'hfffe) begin n_bad++; $display("FAIL wrap_addr got %h want fffe", ifc.imem_addr); end
    tick();
    ifc.imem_done  = 1'b1;
    ifc.imem_rdata = 16'h4abc;
    look();
    tick();
    ifc.imem_done = 1'b0;
    look();
    n_cmp++;
    if (ifc.validF !== 1'b1 || ifc.incPCF !== 16'h0000 || ifc.instructionF !== 16'h4abc) begin
      n_bad++;
      $display("FAIL wrap_inc got valid %b inc %h instr %h want 1 0000 4abc", ifc.validF, ifc.incPCF, ifc.instructionF);
    end
    ifc.stallD = 1'b0;
    mem_en     = 1'b1;
    tick();
  endtask

  // Model: the consumed stream is the memory walked at +2 from the last redirect target.
  task automatic test_random();
    logic [15:0] exp_pc;
    logic [15:0] prev_i;
    logic [15:0] prev_p;
    bit          prev_hold;
    int          consumed;
    mem_ovr.delete();
    lat_lo = 1; lat_hi = 4;
    do_reset();
    exp_pc    = 16'h0000;
    prev_hold = 1'b0;
    prev_i    = 16'h0000;
    prev_p    = 16'h0000;
    consumed  = 0;
    for (int i = 0; i < 400; i++) begin
      ifc.stallD     = ($urandom_range(9, 0) < 3);
      ifc.redirect   = !ifc.imem_req && !ifc.haltF && ($urandom_range(19, 0) == 0);
      ifc.redirectPC = 16'($urandom);
      look();
      if (prev_hold) begin
        n_cmp++;
        if (ifc.instructionF !== prev_i || ifc.incPCF !== prev_p) begin
          n_bad++;
          $display("FAIL rnd_hold got %h %h want %h %h", ifc.instructionF, ifc.incPCF, prev_i, prev_p);
        end
      end
      if (ifc.redirect) begin
        n_cmp++; if (ifc.validF !== 1'b0) begin n_bad++; $display("FAIL rnd_mask got validF %b want 0", ifc.validF); end
        exp_pc = ifc.redirectPC;
      end else if (ifc.validF && !ifc.stallD) begin
        n_cmp++;
        if (ifc.instructionF !== mem_val(exp_pc) || ifc.incPCF !== exp_pc + 16'd2 || ifc.errF !== 1'b0) begin
          n_bad++;
          $display("FAIL rnd_consume got %h %h %b want %h %h 0",
                   ifc.instructionF, ifc.incPCF, ifc.errF, mem_val(exp_pc), exp_pc + 16'd2);
        end
        exp_pc = exp_pc + 16'd2;
        consumed++;
      end
      if (ifc.imem_req) begin
        n_cmp++; if (ifc.imem_addr !== exp_pc) begin n_bad++; $display("FAIL rnd_addr got %h want %h", ifc.imem_addr, exp_pc); end
      end
      prev_hold = ifc.validF && ifc.stallD;
      prev_i    = ifc.instructionF;
      prev_p    = ifc.incPCF;
      tick();
    end
    ifc.redirect = 1'b0;
    ifc.stallD   = 1'b0;
    n_cmp++; if (consumed < 30) begin n_bad++; $display("FAIL rnd_progress got %0d consumed want >= 30", consumed); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_redirect_wait();
    test_halt();
    test_error();
    test_reset_wait();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
